ac97_frame_decoder: RTL



---
 rtl/ac97_frame_decoder.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/ac97_frame_decoder.sv
// ac97_frame_decoder: codec-side AC97 link receiver.
// Deframes sync/sdata_out into the slot-0 tag, the command address and data
// (slots 1-2) and the PCM left/right samples (slots 3-4).
// Optional feature macro: AC97_DECODER_STATUS_EN adds a 64x16 shadow register
// file that answers register reads on sdata_in in the frame after the read.
module ac97_frame_decoder #(
    parameter int PCM_BITS = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sync,
    input  logic                sdata_out,
    output logic                sdata_in,
    output logic                frame_valid,
    output logic [15:0]         tag,
    output logic                cmd_valid,
    output logic                cmd_read,
    output logic [6:0]          cmd_addr,
    output logic [15:0]         cmd_data,
    output logic                pcm_valid,
    output logic [PCM_BITS-1:0] pcm_left,
    output logic [PCM_BITS-1:0] pcm_right,
    output logic                sync_error
);

    typedef enum logic {HUNT, FRAME} state_t;

    state_t      state_reg;
    logic [7:0]  cnt_reg;          // index of the bit sampled on the next edge
    logic [19:0] shift_reg;
    logic        sync_prev_reg;
    logic [15:0] tag_sh_reg;
    logic [19:0] slot1_sh_reg;
    logic [19:0] slot2_sh_reg;
    logic [19:0] slot3_sh_reg;
    logic [19:0] slot4_sh_reg;

    logic [19:0] word;
    logic        rise;
    logic        early_rise;
    logic        bad_level;
    logic        complete;

    // Shift word including the bit sampled this edge, and framing decisions.
    assign word       = {shift_reg[18:0], sdata_out};
    assign rise       = sync & ~sync_prev_reg;
    assign early_rise = (state_reg == FRAME) & rise & (cnt_reg != 8'd0);
    assign bad_level  = (state_reg == FRAME) & ~early_rise & ((cnt_reg < 8'd16) != sync);
    assign complete   = (state_reg == FRAME) & ~early_rise & ~bad_level & (cnt_reg == 8'd255);

    // Framing FSM: bit counter, slot capture into shadows, output publish at b=255.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= HUNT;
            cnt_reg       <= 8'd0;
            shift_reg     <= 20'd0;
            sync_prev_reg <= 1'b0;
            tag_sh_reg    <= 16'd0;
            slot1_sh_reg  <= 20'd0;
            slot2_sh_reg  <= 20'd0;
            slot3_sh_reg  <= 20'd0;
            slot4_sh_reg  <= 20'd0;
            frame_valid   <= 1'b0;
            tag           <= 16'd0;
            cmd_valid     <= 1'b0;
            cmd_read      <= 1'b0;
            cmd_addr      <= 7'd0;
            cmd_data      <= 16'd0;
            pcm_valid     <= 1'b0;
            pcm_left      <= '0;
            pcm_right     <= '0;
            sync_error    <= 1'b0;
        end else begin
            sync_prev_reg <= sync;
            shift_reg     <= word;
            frame_valid   <= 1'b0;
            cmd_valid     <= 1'b0;
            pcm_valid     <= 1'b0;
            sync_error    <= 1'b0;
            if (state_reg == HUNT) begin
                // The sample that first sees sync high is b=0.
                if (rise) begin
                    state_reg <= FRAME;
                    cnt_reg   <= 8'd1;
                end
            end else if (early_rise) begin
                // Early rise restarts the frame in place; this sample is b=0.
                sync_error <= 1'b1;
                cnt_reg    <= 8'd1;
            end else if (bad_level) begin
                sync_error <= 1'b1;
                state_reg  <= HUNT;
                cnt_reg    <= 8'd0;
            end else begin
                cnt_reg <= cnt_reg + 8'd1;
                case (cnt_reg)
                    8'd15:  tag_sh_reg   <= word[15:0];
                    8'd35:  slot1_sh_reg <= word;
                    8'd55:  slot2_sh_reg <= word;
                    8'd75:  slot3_sh_reg <= word;
                    8'd95:  slot4_sh_reg <= word;
                    8'd255: begin
                        frame_valid <= 1'b1;
                        tag         <= tag_sh_reg;
                        cmd_valid   <= tag_sh_reg[15] & tag_sh_reg[14];
                        pcm_valid   <= tag_sh_reg[15] & tag_sh_reg[12] & tag_sh_reg[11];
                        cmd_read    <= slot1_sh_reg[19];
                        cmd_addr    <= slot1_sh_reg[18:12];
                        cmd_data    <= slot2_sh_reg[19:4];
                        pcm_left    <= slot3_sh_reg[19 -: PCM_BITS];
                        pcm_right   <= slot4_sh_reg[19 -: PCM_BITS];
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef AC97_DECODER_STATUS_EN
    logic [15:0] mem [0:63];
    logic [63:0] file_valid_reg;   // stands in for a reset of the RAM contents
    logic [15:0] rd_data_reg;
    logic        rd_valid_reg;
    logic        resp_reg;
    logic        sdata_in_reg;
    logic        wr_en;
    logic [5:0]  idx;
    logic [15:0] resp_word;
    logic        arm;
    logic [7:0]  nidx;
    logic [2:0]  addr_sel;
    logic [3:0]  data_sel;
    logic        resp_bit;

    assign wr_en     = cmd_valid & ~cmd_read & tag[13];
    assign idx       = cmd_addr[6:1];
    assign resp_word = rd_valid_reg ? rd_data_reg : 16'd0;
    assign arm       = tag_sh_reg[15] & tag_sh_reg[14] & slot1_sh_reg[19];
    assign nidx      = cnt_reg + 8'd1;
    assign addr_sel  = 3'(8'd23 - nidx);
    assign data_sel  = 4'(8'd51 - nidx);
    assign sdata_in  = sdata_in_reg;

    // Shadow register RAM: write the cycle after a write frame, registered read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= cmd_data;
        end
        rd_data_reg <= mem[idx];
    end

    // Per-entry written flags so that unwritten entries read back as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            file_valid_reg <= 64'd0;
            rd_valid_reg   <= 1'b0;
        end else begin
            if (wr_en) begin
                file_valid_reg[idx] <= 1'b1;
            end
            rd_valid_reg <= file_valid_reg[idx];
        end
    end

    // Response bit for the next index: tag 15..13, read address, file data.
    always_comb begin
        resp_bit = 1'b0;
        if (nidx <= 8'd2) begin
            resp_bit = 1'b1;
        end else if (nidx >= 8'd17 && nidx <= 8'd23) begin
            resp_bit = cmd_addr[addr_sel];
        end else if (nidx >= 8'd36 && nidx <= 8'd51) begin
            resp_bit = resp_word[data_sel];
        end
    end

    // Arm a response at read-frame completion; drive it during the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_reg     <= 1'b0;
            sdata_in_reg <= 1'b0;
        end else if (state_reg == HUNT || early_rise || bad_level) begin
            resp_reg     <= 1'b0;
            sdata_in_reg <= 1'b0;
        end else if (complete) begin
            resp_reg     <= arm;
            sdata_in_reg <= arm;
        end else begin
            sdata_in_reg <= resp_reg & resp_bit;
        end
    end
`else
    assign sdata_in = 1'b0;
`endif

endmodule
